// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row sync, ghost rejection, frame debounce, one-hot key code.
// Optional auto-repeat of key_valid while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan #(
    parameter int SCAN_DIV            = 50000,
    parameter int DEBOUNCE_FRAMES     = 5,
    parameter int REPEAT_DELAY_FRAMES = 125,
    parameter int REPEAT_RATE_FRAMES  = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] onehot,
    output logic        key_valid,
    output logic        key_down
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] DEB_MAX  = SW'(DEBOUNCE_FRAMES);

    logic [3:0]    row_meta, row_sync;
    logic [DW-1:0] div_cnt;
    logic [1:0]    col_idx;
    logic [15:0]   frame_acc, frame_next, frame_code, candidate;
    logic [SW-1:0] stable_cnt;
    logic          tick, frame_end, single_hot, update;

    // Rows idle high through the pull-ups, so the synchronizer resets to "no key".
    // NOTE: every register here uses <= so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    assign tick      = (div_cnt == DIV_LAST);
    assign frame_end = tick && (col_idx == 2'd3);
    assign col_out   = ~(4'b0001 << col_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            col_idx <= 2'd0;
        end else if (tick) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // NOTE: defaulting frame_next before the loop keeps this block purely combinational.
    always_comb begin
        frame_next = frame_acc;
        for (int r = 0; r < 4; r++) begin
            frame_next[{2'(r), col_idx}] = ~row_sync[r];
        end
    end

    // Zero or several bits (including ghosts) both collapse to "no key".
    assign single_hot = (frame_next != 16'd0) && ((frame_next & (frame_next - 16'd1)) == 16'd0);
    assign frame_code = single_hot ? frame_next : 16'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_acc  <= 16'd0;
            candidate  <= 16'd0;
            stable_cnt <= '0;
        end else if (tick) begin
            if (col_idx == 2'd3) begin
                frame_acc <= 16'd0;
                if (frame_code == candidate) begin
                    if (stable_cnt != DEB_MAX) begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end
                end else begin
                    candidate  <= frame_code;
                    stable_cnt <= SW'(1);
                end
            end else begin
                frame_acc <= frame_next;
            end
        end
    end

    assign update = (stable_cnt == DEB_MAX) && (candidate != onehot);

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ? REPEAT_DELAY_FRAMES
                                                                         : REPEAT_RATE_FRAMES;
    localparam int RW = $clog2(RPT_MAX + 1);

    logic [RW-1:0] rpt_cnt, rpt_next;
    logic          rpt_armed, rpt_fire, repeat_pulse;

    // First repeat waits the long delay; once armed, the short rate applies.
    assign rpt_next     = rpt_cnt + 1'b1;
    assign rpt_fire     = rpt_armed ? (rpt_next == RW'(REPEAT_RATE_FRAMES))
                                    : (rpt_next == RW'(REPEAT_DELAY_FRAMES));
    assign repeat_pulse = !update && frame_end && key_down && rpt_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (update) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (frame_end && key_down) begin
            if (rpt_fire) begin
                rpt_cnt   <= '0;
                rpt_armed <= 1'b1;
            end else begin
                rpt_cnt <= rpt_next;
            end
        end
    end
`else
    logic repeat_pulse;
    assign repeat_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot    <= 16'd0;
            key_down  <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= repeat_pulse;
            if (update) begin
                onehot    <= candidate;
                key_down  <= |candidate;
                key_valid <= |candidate;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a keypad row model and an expected-event scoreboard.
// Builds with or without KEYPAD_REPEAT_EN; the repeat timing check runs only when it is defined.
module tb_keypad_scan;

    typedef struct packed {
        logic [15:0] code;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] onehot;
    logic        key_valid;
    logic        key_down;

    logic [15:0] keys = 16'h0000;
    logic [15:0] prev_onehot = 16'h0000;
    exp_t        exp_q[$];
    int          pulse_times[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          pulse_cnt = 0;
    int          cyc = 0;

    keypad_scan #(
        .SCAN_DIV            (4),
        .DEBOUNCE_FRAMES     (3),
        .REPEAT_DELAY_FRAMES (4),
        .REPEAT_RATE_FRAMES  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .onehot    (onehot),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column while that column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] code, input logic valid);
        exp_t e;
        e.code  = code;
        e.valid = valid;
        exp_q.push_back(e);
    endtask

    task automatic wait_onehot(input string tag, input logic [15:0] val, input int lo, input int hi);
        int n = 0;
        while (onehot !== val && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_value"}, onehot, val);
        check({tag, "_latency_in_range"}, (n >= lo && n <= hi), 1);
        if (n < lo || n > hi) $display("  %s latency was %0d cycles, allowed %0d..%0d", tag, n, lo, hi);
    endtask

    task automatic frames(input int n);
        repeat (n * 16) @(negedge clk);
    endtask

    // Scoreboard: every onehot change must match the next expected event.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            prev_onehot = onehot;
        end else begin
            if (key_valid) begin
                pulse_cnt++;
                pulse_times.push_back(cyc);
            end
            if (onehot !== prev_onehot) begin
                check("onehot_at_most_one_bit", $onehot0(onehot), 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_onehot_change", onehot, prev_onehot);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_onehot", onehot, e.code);
                    check("sb_key_valid", key_valid, e.valid);
                    check("sb_key_down", key_down, |e.code);
                end
            end else if (key_valid) begin
`ifndef KEYPAD_REPEAT_EN
                check("stray_key_valid", key_valid, 0);
`endif
            end
            prev_onehot = onehot;
        end
    end

    initial begin
        int p0;
        logic [3:0] exp_cols [4];
        exp_cols[0] = 4'b1101;
        exp_cols[1] = 4'b1011;
        exp_cols[2] = 4'b0111;
        exp_cols[3] = 4'b1110;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_col_out", col_out, 4'b1110);
        check("rst_onehot", onehot, 16'h0000);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_down", key_down, 0);
        rst_n = 1'b1;

        // Column walk, four cycles per column
        repeat (3) @(negedge clk);
        check("col_hold_0", col_out, 4'b1110);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) @(negedge clk);
            else repeat (4) @(negedge clk);
            check($sformatf("col_step_%0d", i), col_out, exp_cols[i]);
        end
        frames(2);

        // Clean press and release of row1/col2
        p0 = pulse_cnt;
        keys = 16'h0040;
        push_exp(16'h0040, 1'b1);
        wait_onehot("press", 16'h0040, 32, 70);
        check("press_key_down", key_down, 1);
        frames(2);
        check("press_pulses", pulse_cnt - p0, 1);
        keys = 16'h0000;
        push_exp(16'h0000, 1'b0);
        wait_onehot("release", 16'h0000, 32, 70);
        check("release_key_down", key_down, 0);
        frames(2);

        // Bounce on alternate frames, then hold
        p0 = pulse_cnt;
        for (int i = 0; i < 4; i++) begin
            keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
            frames(1);
        end
        check("bounce_onehot", onehot, 16'h0000);
        keys = 16'h0040;
        push_exp(16'h0040, 1'b1);
        wait_onehot("bounce_hold", 16'h0040, 32, 70);
        frames(2);
        check("bounce_pulses", pulse_cnt - p0, 1);
        keys = 16'h0000;
        push_exp(16'h0000, 1'b0);
        wait_onehot("bounce_release", 16'h0000, 32, 70);
        frames(2);

        // Two keys together are rejected; dropping one qualifies the other
        p0 = pulse_cnt;
        keys = 16'h8001;
        frames(10);
        check("two_key_onehot", onehot, 16'h0000);
        check("two_key_pulses", pulse_cnt - p0, 0);
        keys = 16'h0001;
        push_exp(16'h0001, 1'b1);
        wait_onehot("single_after_two", 16'h0001, 32, 70);
        frames(2);
        check("single_after_two_pulses", pulse_cnt - p0, 1);
        keys = 16'h0000;
        push_exp(16'h0000, 1'b0);
        wait_onehot("two_key_release", 16'h0000, 32, 70);
        frames(2);

        // Direct key change with no release frame
        keys = 16'h0008;
        push_exp(16'h0008, 1'b1);
        wait_onehot("change_first", 16'h0008, 32, 70);
        keys = 16'h0200;
        push_exp(16'h0200, 1'b1);
        wait_onehot("change_second", 16'h0200, 32, 70);
        keys = 16'h0000;
        push_exp(16'h0000, 1'b0);
        wait_onehot("change_release", 16'h0000, 32, 70);
        frames(2);

        // Reset mid-press clears asynchronously, then the held key re-qualifies
        keys = 16'h0040;
        push_exp(16'h0040, 1'b1);
        wait_onehot("pre_reset_press", 16'h0040, 32, 70);
        frames(1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_onehot", onehot, 16'h0000);
        check("async_rst_key_down", key_down, 0);
        check("async_rst_col_out", col_out, 4'b1110);
        repeat (3) @(negedge clk);
        pulse_times.delete();
        rst_n = 1'b1;
        push_exp(16'h0040, 1'b1);
        wait_onehot("requalify", 16'h0040, 32, 70);
`ifdef KEYPAD_REPEAT_EN
        frames(9);
        check("repeat_pulse_count", pulse_times.size(), 4);
        if (pulse_times.size() >= 4) begin
            check("repeat_delay_in_range",
                  (pulse_times[1] - pulse_times[0] >= 63) && (pulse_times[1] - pulse_times[0] <= 64), 1);
            check("repeat_rate_1", pulse_times[2] - pulse_times[1], 32);
            check("repeat_rate_2", pulse_times[3] - pulse_times[2], 32);
        end
        check("repeat_onehot_steady", onehot, 16'h0040);
`else
        frames(2);
        check("requalify_pulses", pulse_times.size(), 1);
`endif
        keys = 16'h0000;
        push_exp(16'h0000, 1'b0);
        wait_onehot("final_release", 16'h0000, 32, 70);
        frames(1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
